// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the byte-lane data memory.
//               size_e  - funct3 access-size encodings
//               state_e - request sequencer states
//               size_bytes() - access size in bytes
//               extend()     - sign/zero extension of an LSB-aligned load
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int c_BYTE_W    = 8;
    localparam int c_MAX_LANES = 8;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_D  = 3'b011,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101,
        SZ_WU = 3'b110
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    // 1, 2, 4 or 8 bytes; bit 2 of funct3 only selects the extension kind.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        return 4'd1 << size[1:0];
    endfunction

    // funct3[2]=0 sign-extends, funct3[2]=1 zero-extends; 8-byte loads pass through.
    function automatic logic [63:0] extend(input logic [63:0] data, input logic [2:0] size);
        logic        sgn;
        logic [63:0] res;
        sgn = ~size[2];
        case (size[1:0])
            2'd0:    res = {{56{sgn & data[7]}},  data[7:0]};
            2'd1:    res = {{48{sgn & data[15]}}, data[15:0]};
            2'd2:    res = {{32{sgn & data[31]}}, data[31:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_bank.sv
// ============================================================================
// Module      : dmem_byte_bank
// Description : One 8-bit-wide single-port synchronous RAM lane.
//               Write when we=1; read data registered (old contents on a
//               same-cycle write to the same address).
// Ports       : clk   - clock
//               we    - write enable for this lane
//               addr  - word address
//               wdata - byte to write
//               rdata - registered read byte
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_byte_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [c_BYTE_W-1:0]   wdata,
    output logic [c_BYTE_W-1:0]   rdata
);

    logic [c_BYTE_W-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_lanes.sv
// ============================================================================
// Module      : data_mem_lanes
// Description : Byte-lane, word-organised data memory with a valid/ready
//               request port and a registered one-cycle response pulse.
//               Handles misaligned accesses that stay inside one word; with
//               DMEM_MISALIGN_SPLIT_EN defined, accesses crossing a word
//               boundary are split into two beats, otherwise they are
//               answered with rsp_err.
// Ports       : clk, rst_n (async active-low)
//               req_valid/req_ready, req_write, req_size (funct3),
//               req_addr (byte), req_wdata (LSB-aligned)
//               rsp_valid (pulse), rsp_rdata (extended load data), rsp_err
// Macro       : DMEM_MISALIGN_SPLIT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_lanes
    import dmem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 17,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int c_NLANES = DATA_WIDTH / c_BYTE_W;
    localparam int c_LIW    = $clog2(c_NLANES);
    localparam int c_WAW    = ADDR_WIDTH - c_LIW;

    // ------------------------------------------------------------------
    // Latched request
    // ------------------------------------------------------------------
    state_e                r_state;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [c_LIW-1:0]      r_off;
    logic [4:0]            r_end;     // off + bytes, one past the last lane touched
    logic [c_WAW-1:0]      r_word;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic                  r_cross;
    logic [DATA_WIDTH-1:0] r_beat0;   // first-beat read data of a crossing load

    // ------------------------------------------------------------------
    // Accept-time classification
    // ------------------------------------------------------------------
    logic             w_accept;
    logic [c_LIW-1:0] w_req_off;
    logic [4:0]       w_req_end;
    logic             w_overflow;
    logic             w_illegal;
    logic             w_req_err;
    logic             w_req_cross;

    assign w_accept   = req_valid && req_ready;
    assign w_req_off  = req_addr[c_LIW-1:0];
    assign w_req_end  = {1'b0, size_bytes(req_size)} + 5'(w_req_off);
    assign w_overflow = w_req_end > 5'(c_NLANES);
    assign w_illegal  = (req_size == 3'b111) ||
                        ((DATA_WIDTH == 32) && ((req_size == SZ_D) || (req_size == SZ_WU)));

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign w_req_err   = w_illegal;
    assign w_req_cross = w_overflow && !w_illegal;
`else
    assign w_req_err   = w_illegal || w_overflow;
    assign w_req_cross = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Lane banks
    // ------------------------------------------------------------------
    logic [c_NLANES-1:0]   bank_we;
    logic [c_WAW-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wd;
    logic [DATA_WIDTH-1:0] bank_rd;

    // Second beat addresses the next word; wrap at the top is natural.
    assign bank_addr = (r_state == BEAT1) ? r_word + 1'b1 : r_word;

    always_comb begin
        logic [c_LIW-1:0] src;
        logic             en;
        bank_we = '0;
        bank_wd = '0;
        for (int l = 0; l < c_NLANES; l++) begin
            // Store byte i lands on lane (off+i) mod NLANES in either beat,
            // so a single left rotation by off serves both beats.
            src = c_LIW'(l) - r_off;
            bank_wd[l*c_BYTE_W +: c_BYTE_W] = r_wdata[src*c_BYTE_W +: c_BYTE_W];
            en = 1'b0;
            if (r_state == BEAT0) begin
                en = (5'(l) >= 5'(r_off)) && (5'(l) < r_end);
            end else if (r_state == BEAT1) begin
                en = 5'(l + c_NLANES) < r_end;
            end
            bank_we[l] = en && r_write && !r_err;
        end
    end

    for (genvar g = 0; g < c_NLANES; g++) begin : g_lane
        dmem_byte_bank #(
            .ADDR_WIDTH (c_WAW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .addr  (bank_addr),
            .wdata (bank_wd[g*c_BYTE_W +: c_BYTE_W]),
            .rdata (bank_rd[g*c_BYTE_W +: c_BYTE_W])
        );
    end

    // ------------------------------------------------------------------
    // Load assembly: lanes at or above off come from the first beat, lanes
    // below off from the second; then rotate right by off and extend.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_merged;
    logic [63:0]           w_rot64;
    logic [DATA_WIDTH-1:0] w_load;

    always_comb begin
        logic [DATA_WIDTH-1:0] beat0_src;
        logic [c_LIW-1:0]      src;
        beat0_src = r_cross ? r_beat0 : bank_rd;
        w_merged  = '0;
        w_rot64   = '0;
        for (int l = 0; l < c_NLANES; l++) begin
            if (c_LIW'(l) >= r_off) begin
                w_merged[l*c_BYTE_W +: c_BYTE_W] = beat0_src[l*c_BYTE_W +: c_BYTE_W];
            end else begin
                w_merged[l*c_BYTE_W +: c_BYTE_W] = bank_rd[l*c_BYTE_W +: c_BYTE_W];
            end
        end
        for (int i = 0; i < c_NLANES; i++) begin
            src = c_LIW'(i) + r_off;
            w_rot64[i*c_BYTE_W +: c_BYTE_W] = w_merged[src*c_BYTE_W +: c_BYTE_W];
        end
        w_load = DATA_WIDTH'(extend(w_rot64, r_size));
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_write   <= 1'b0;
            r_size    <= '0;
            r_off     <= '0;
            r_end     <= '0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_cross   <= 1'b0;
            r_beat0   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_size    <= req_size;
                        r_off     <= w_req_off;
                        r_end     <= w_req_end;
                        r_word    <= req_addr[ADDR_WIDTH-1:c_LIW];
                        r_wdata   <= req_wdata;
                        r_err     <= w_req_err;
                        r_cross   <= w_req_cross;
                        req_ready <= 1'b0;
                        r_state   <= BEAT0;
                    end
                end
                BEAT0: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                    r_state <= r_cross ? BEAT1 : RESP;
`else
                    r_state <= RESP;
`endif
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                BEAT1: begin
                    r_beat0 <= bank_rd;
                    r_state <= RESP;
                end
`endif
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    rsp_rdata <= (r_write || r_err) ? '0 : w_load;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
